// File: rtl/sys_mem_blk_xfr.sv
// sys_mem_blk_xfr: block-transfer engine on one system-memory arbiter port.
// Software programs start address, length and direction over the local bus.
// Read transfers stream returned words to a ready/valid sink, gated by read
// credits so the un-throttled return path can never overrun the return FIFO.
// Write transfers drain a ready/valid source into sequential memory writes.
module sys_mem_blk_xfr #(
  parameter int MEM_DATA_W      = 32,
  parameter int MEM_ADDR_W      = 27,
  parameter int LB_DATA_W       = 32,
  parameter int LB_ADDR_W       = 8,
  parameter int LEN_W           = 16,
  parameter int MAX_OUTSTANDING = 8,
  parameter logic [LB_DATA_W-1:0] DEFAULT_DATA_VAL = 'hdeadbabe
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lb_wr_en_i,
  input  logic                  lb_rd_en_i,
  input  logic [LB_ADDR_W-1:0]  lb_addr_i,
  input  logic [LB_DATA_W-1:0]  lb_wr_data_i,
  output logic                  lb_wr_valid_o,
  output logic                  lb_rd_valid_o,
  output logic [LB_DATA_W-1:0]  lb_rd_data_o,
  input  logic                  mem_wait_i,
  output logic                  mem_wren_o,
  output logic                  mem_rden_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [MEM_DATA_W-1:0] mem_wdata_o,
  input  logic                  mem_rd_valid_i,
  input  logic [MEM_DATA_W-1:0] mem_rdata_i,
  input  logic                  src_valid_i,
  input  logic [MEM_DATA_W-1:0] src_data_i,
  output logic                  src_ready_o,
  output logic                  snk_valid_o,
  output logic [MEM_DATA_W-1:0] snk_data_o,
  input  logic                  snk_ready_i,
  output logic                  xfr_done_o
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CREDITS_MAX = CNT_W'(MAX_OUTSTANDING);

  localparam logic [LB_ADDR_W-1:0] ADDR_CTRL   = LB_ADDR_W'(0);
  localparam logic [LB_ADDR_W-1:0] ADDR_STATUS = LB_ADDR_W'(1);
  localparam logic [LB_ADDR_W-1:0] ADDR_START  = LB_ADDR_W'(2);
  localparam logic [LB_ADDR_W-1:0] ADDR_LEN    = LB_ADDR_W'(3);
  localparam logic [LB_ADDR_W-1:0] ADDR_REMAIN = LB_ADDR_W'(4);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_REQ   = 3'd1,
    RD_DRAIN = 3'd2,
    WR_REQ   = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Software-visible registers
  logic                  dir_q;
  logic [MEM_ADDR_W-1:0] start_addr_q;
  logic [LEN_W-1:0]      len_q;
  logic                  done_q;
  logic                  aborted_q;

  // Local bus response registers
  logic                  lb_wr_valid_q;
  logic                  lb_rd_valid_q;
  logic [LB_DATA_W-1:0]  lb_rd_data_q;
  logic [LB_DATA_W-1:0]  lb_rd_mux;

  // Transfer datapath
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]      remain_q;
  logic [CNT_W-1:0]      credits_q, credits_d;
  logic                  discard_q;

  // Read-return FIFO
  logic [MEM_DATA_W-1:0] fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;

  logic wr_ctrl, start_cmd, abort_cmd, rd_status;
  logic busy, rd_issue, wr_issue, issue, snk_hs;
  logic abort_rd, abort_wr, rd_active, push;
  logic unused_lb_bits;

  assign wr_ctrl   = lb_wr_en_i && (lb_addr_i == ADDR_CTRL);
  assign start_cmd = wr_ctrl && lb_wr_data_i[0];
  assign abort_cmd = wr_ctrl && lb_wr_data_i[2];
  assign rd_status = lb_rd_en_i && (lb_addr_i == ADDR_STATUS);

  assign busy      = (state_q != IDLE);
  assign rd_issue  = mem_rden_o && !mem_wait_i;
  assign wr_issue  = mem_wren_o && !mem_wait_i;
  assign issue     = rd_issue || wr_issue;
  assign snk_hs    = snk_valid_o && snk_ready_i;
  assign abort_rd  = (state_q == RD_REQ) && abort_cmd;
  assign abort_wr  = (state_q == WR_REQ) && abort_cmd;
  assign rd_active = (state_q == RD_REQ) || (state_q == RD_DRAIN);
  // Returns are only kept while a live read is running; the abort cycle drops them too
  assign push      = mem_rd_valid_i && rd_active && !discard_q && !abort_rd;

  assign unused_lb_bits = ^lb_wr_data_i[LB_DATA_W-1:MEM_ADDR_W];

  // Readback mux for the register map
  always_comb begin
    lb_rd_mux = DEFAULT_DATA_VAL;
    case (lb_addr_i)
      ADDR_CTRL:   lb_rd_mux = LB_DATA_W'({dir_q, 1'b0});
      ADDR_STATUS: lb_rd_mux = LB_DATA_W'({aborted_q, done_q, busy});
      ADDR_START:  lb_rd_mux = LB_DATA_W'(start_addr_q);
      ADDR_LEN:    lb_rd_mux = LB_DATA_W'(len_q);
      ADDR_REMAIN: lb_rd_mux = LB_DATA_W'(remain_q);
      default:     lb_rd_mux = DEFAULT_DATA_VAL;
    endcase
  end

  // Local bus acknowledges and registered read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_wr_valid_q <= 1'b0;
      lb_rd_valid_q <= 1'b0;
      lb_rd_data_q  <= '0;
    end else begin
      lb_wr_valid_q <= lb_wr_en_i;
      lb_rd_valid_q <= lb_rd_en_i;
      if (lb_rd_en_i) lb_rd_data_q <= lb_rd_mux;
    end
  end

  // Config registers and sticky status; a set beats a same-cycle read-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q        <= 1'b0;
      start_addr_q <= '0;
      len_q        <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      if (wr_ctrl) dir_q <= lb_wr_data_i[1];
      if (lb_wr_en_i && (lb_addr_i == ADDR_START)) start_addr_q <= lb_wr_data_i[MEM_ADDR_W-1:0];
      if (lb_wr_en_i && (lb_addr_i == ADDR_LEN))   len_q        <= lb_wr_data_i[LEN_W-1:0];
      if (state_q == DONE)  done_q <= 1'b1;
      else if (rd_status)   done_q <= 1'b0;
      if (abort_rd || abort_wr) aborted_q <= 1'b1;
      else if (rd_status)       aborted_q <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_cmd) begin
          if (len_q == '0)          state_d = DONE;
          else if (lb_wr_data_i[1]) state_d = WR_REQ;
          else                      state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (abort_cmd)                                   state_d = RD_DRAIN;
        else if (rd_issue && (remain_q == LEN_W'(1)))    state_d = RD_DRAIN;
      end
      RD_DRAIN: begin
        if (credits_q == CREDITS_MAX) state_d = DONE;
      end
      WR_REQ: begin
        if (abort_cmd)                                   state_d = DONE;
        else if (wr_issue && (remain_q == LEN_W'(1)))    state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: request strobes, source ready and completion pulse
  always_comb begin
    mem_rden_o  = (state_q == RD_REQ) && (credits_q != '0);
    mem_wren_o  = (state_q == WR_REQ) && src_valid_i;
    mem_wdata_o = (state_q == WR_REQ) ? src_data_i : '0;
    src_ready_o = (state_q == WR_REQ) && !mem_wait_i;
    xfr_done_o  = (state_q == DONE);
  end

  // Credit accounting: an abort returns the credits of everything flushed from the FIFO,
  // after which each late return gives its credit back instead of reaching the sink
  always_comb begin
    credits_d = credits_q;
    if (abort_rd)
      credits_d = credits_q - CNT_W'(rd_issue) + fifo_cnt_q + CNT_W'(mem_rd_valid_i);
    else if (discard_q)
      credits_d = credits_q + CNT_W'(mem_rd_valid_i && rd_active);
    else
      credits_d = credits_q - CNT_W'(rd_issue) + CNT_W'(snk_hs);
  end

  // Address, remaining count, credits and discard mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      remain_q  <= '0;
      credits_q <= CREDITS_MAX;
      discard_q <= 1'b0;
    end else begin
      if ((state_q == IDLE) && start_cmd) begin
        addr_q   <= start_addr_q;
        remain_q <= len_q;
      end else if (issue) begin
        addr_q   <= addr_q + MEM_ADDR_W'(1);
        remain_q <= remain_q - LEN_W'(1);
      end
      credits_q <= credits_d;
      if (abort_rd)              discard_q <= 1'b1;
      else if (state_q == DONE)  discard_q <= 1'b0;
    end
  end

  // Return FIFO occupancy next value
  always_comb begin
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(snk_hs);
  end

  // Return FIFO pointers; an abort flushes everything still queued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else if (abort_rd) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (snk_hs) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Return FIFO storage, written only when a return is kept
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_rdata_i;
  end

  assign snk_valid_o   = (fifo_cnt_q != '0);
  assign snk_data_o    = snk_valid_o ? fifo_mem[rd_ptr_q] : '0;
  assign mem_addr_o    = addr_q;
  assign lb_wr_valid_o = lb_wr_valid_q;
  assign lb_rd_valid_o = lb_rd_valid_q;
  assign lb_rd_data_o  = lb_rd_data_q;

endmodule

// File: tb/tb_sys_mem_blk_xfr.sv
// tb_sys_mem_blk_xfr: scoreboard bench for the block-transfer engine.
// Stimulus pushes expected memory requests, sink beats and local bus read
// data into queues; a monitor pops and compares whenever the DUT presents
// them. A small memory responder returns reads after a programmable latency.
module tb_sys_mem_blk_xfr;

  localparam int AW = 27;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lb_wr_en = 1'b0, lb_rd_en = 1'b0;
  logic [7:0]    lb_addr = '0;
  logic [31:0]   lb_wr_data = '0;
  logic          lb_wr_valid, lb_rd_valid;
  logic [31:0]   lb_rd_data;
  logic          mem_wait = 1'b0;
  logic          mem_wren, mem_rden;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd_valid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          src_valid = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          src_ready;
  logic          snk_valid;
  logic [DW-1:0] snk_data;
  logic          snk_ready = 1'b0;
  logic          xfr_done;

  sys_mem_blk_xfr dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lb_wr_en_i     (lb_wr_en),
    .lb_rd_en_i     (lb_rd_en),
    .lb_addr_i      (lb_addr),
    .lb_wr_data_i   (lb_wr_data),
    .lb_wr_valid_o  (lb_wr_valid),
    .lb_rd_valid_o  (lb_rd_valid),
    .lb_rd_data_o   (lb_rd_data),
    .mem_wait_i     (mem_wait),
    .mem_wren_o     (mem_wren),
    .mem_rden_o     (mem_rden),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rd_valid_i (mem_rd_valid),
    .mem_rdata_i    (mem_rdata),
    .src_valid_i    (src_valid),
    .src_data_i     (src_data),
    .src_ready_o    (src_ready),
    .snk_valid_o    (snk_valid),
    .snk_data_o     (snk_data),
    .snk_ready_i    (snk_ready),
    .xfr_done_o     (xfr_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;
  typedef struct { int due; logic [DW-1:0] data; } ret_t;

  req_t        exp_req_q[$];
  logic [DW-1:0] exp_snk_q[$];
  logic [31:0] exp_lb_q[$];
  ret_t        ret_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_lat = 2;
  int issue_cnt = 0;
  int done_seen = 0;
  int exp_done = 0;
  int base;

  // Memory contents seen by the responder
  function automatic logic [DW-1:0] memData(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ {5'b0, a};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expRead(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_req_q.push_back('{wr: 1'b0, addr: a, data: '0});
    exp_snk_q.push_back(d);
  endtask

  task automatic lbWrite(input logic [7:0] a, input logic [31:0] d);
    lb_wr_en = 1'b1; lb_addr = a; lb_wr_data = d;
    @(posedge clk); #1;
    lb_wr_en = 1'b0;
  endtask

  task automatic lbRead(input logic [7:0] a, input logic [31:0] exp);
    exp_lb_q.push_back(exp);
    lb_rd_en = 1'b1; lb_addr = a;
    @(posedge clk); #1;
    lb_rd_en = 1'b0;
  endtask

  // Program start address and length, then START with the chosen direction
  task automatic applyStimulus(input logic [31:0] start, input logic [31:0] len, input logic dir);
    lbWrite(8'h02, start);
    lbWrite(8'h03, len);
    lbWrite(8'h00, {30'b0, dir, 1'b1});
  endtask

  task automatic waitDone(input string name);
    exp_done++;
    for (int i = 0; i < 600 && done_seen < exp_done; i++) @(negedge clk);
    checkOutput(name, done_seen, exp_done);
    @(posedge clk); #1;
  endtask

  // Monitor: compare every accepted request, sink beat, local bus read and done pulse
  initial begin : monitor
    req_t r;
    logic [DW-1:0] d;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if ((mem_rden || mem_wren) && !mem_wait) begin
          issue_cnt++;
          if (exp_req_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected request: got addr 0x%0h wr=%0b, expected none", mem_addr, mem_wren);
          end else begin
            r = exp_req_q.pop_front();
            checkOutput("req kind", mem_wren, r.wr);
            checkOutput("req addr", mem_addr, r.addr);
            if (r.wr) checkOutput("req wdata", mem_wdata, r.data);
          end
        end
        if (snk_valid && snk_ready) begin
          if (exp_snk_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected snk beat: got 0x%0h, expected none", snk_data);
          end else begin
            d = exp_snk_q.pop_front();
            checkOutput("snk data", snk_data, d);
          end
        end
        if (lb_rd_valid) begin
          if (exp_lb_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected lb read: got 0x%0h, expected none", lb_rd_data);
          end else begin
            d = exp_lb_q.pop_front();
            checkOutput("lb rd data", lb_rd_data, d);
          end
        end
        if (xfr_done) done_seen++;
      end
    end
  end

  // Responder: record accepted reads with their due cycle
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mem_rden && !mem_wait)
        ret_q.push_back('{due: cyc + rd_lat, data: memData(mem_addr)});
    end
  end

  // Responder: present each read return when its cycle arrives
  initial begin
    ret_t r;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
        r = ret_q.pop_front();
        mem_rd_valid = 1'b1;
        mem_rdata    = r.data;
      end else begin
        mem_rd_valid = 1'b0;
        mem_rdata    = '0;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] wvec [3];
    wvec[0] = 32'hAAAA_0001; wvec[1] = 32'hBBBB_0002; wvec[2] = 32'hCCCC_0003;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset ctl outputs", {lb_wr_valid, lb_rd_valid, mem_wren, mem_rden, src_ready, snk_valid, xfr_done}, 0);
    checkOutput("reset data outputs", {lb_rd_data, mem_addr}, 0);
    checkOutput("reset wdata/snk", {mem_wdata, snk_data}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    lbRead(8'h01, 32'h0);
    lbRead(8'h04, 32'h0);
    lbRead(8'h10, 32'hDEADBABE);
    lbWrite(8'h03, 32'd5);
    @(negedge clk);
    checkOutput("lb wr ack", lb_wr_valid, 1);
    @(posedge clk); #1;
    lbRead(8'h03, 32'd5);

    // Read, no stall
    $display("[TB] read no stall");
    snk_ready = 1'b1;
    expRead(27'h100, 32'hC0DE_0100);
    expRead(27'h101, 32'hC0DE_0101);
    expRead(27'h102, 32'hC0DE_0102);
    expRead(27'h103, 32'hC0DE_0103);
    applyStimulus(32'h100, 32'd4, 1'b0);
    waitDone("read done");
    lbRead(8'h01, 32'h2);
    lbRead(8'h01, 32'h0);

    // Credit limit with the sink stalled
    $display("[TB] credit limit");
    snk_ready = 1'b0;
    for (int i = 0; i < 20; i++) expRead(AW'(32'h200 + i), memData(AW'(32'h200 + i)));
    base = issue_cnt;
    applyStimulus(32'h200, 32'd20, 1'b0);
    repeat (25) @(posedge clk);
    @(negedge clk);
    checkOutput("credit rden held", mem_rden, 0);
    checkOutput("credit issued", issue_cnt - base, 8);
    @(posedge clk); #1;
    lbRead(8'h01, 32'h1);
    lbRead(8'h04, 32'd12);
    snk_ready = 1'b1;
    waitDone("credit done");
    lbRead(8'h01, 32'h2);

    // Write under stall
    $display("[TB] write under stall");
    for (int i = 0; i < 3; i++) exp_req_q.push_back('{wr: 1'b1, addr: AW'(32'h300 + i), data: wvec[i]});
    applyStimulus(32'h300, 32'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      src_valid = 1'b1; src_data = wvec[i]; mem_wait = 1'b1;
      repeat (2) begin
        @(negedge clk);
        checkOutput("stall addr", mem_addr, 32'h300 + i);
        checkOutput("stall wdata", mem_wdata, wvec[i]);
        checkOutput("stall src_ready", src_ready, 0);
        @(posedge clk); #1;
      end
      mem_wait = 1'b0;
      @(negedge clk);
      checkOutput("free src_ready", src_ready, 1);
      @(posedge clk); #1;
    end
    src_valid = 1'b0;
    waitDone("write done");
    lbRead(8'h01, 32'h2);

    // Address wrap and zero length
    $display("[TB] wrap and zero length");
    expRead(27'h7FF_FFFE, 32'hC721_FFFE);
    expRead(27'h7FF_FFFF, 32'hC721_FFFF);
    expRead(27'h000_0000, 32'hC0DE_0000);
    expRead(27'h000_0001, 32'hC0DE_0001);
    applyStimulus(32'h07FF_FFFE, 32'd4, 1'b0);
    waitDone("wrap done");
    lbRead(8'h01, 32'h2);
    applyStimulus(32'h50, 32'd0, 1'b0);
    waitDone("zero len done");
    lbRead(8'h01, 32'h2);
    lbRead(8'h04, 32'h0);

    // Abort a read with returns still in flight
    $display("[TB] abort read");
    rd_lat = 3;
    for (int i = 0; i < 5; i++) exp_req_q.push_back('{wr: 1'b0, addr: AW'(32'h400 + i), data: '0});
    exp_snk_q.push_back(32'hC0DE_0400);
    exp_snk_q.push_back(32'hC0DE_0401);
    base = issue_cnt;
    applyStimulus(32'h400, 32'd16, 1'b0);
    for (int i = 0; i < 50 && (issue_cnt - base) < 5; i++) @(posedge clk);
    #1;
    mem_wait = 1'b1;
    lbWrite(8'h00, 32'h4);
    mem_wait = 1'b0;
    waitDone("abort done");
    lbRead(8'h04, 32'd11);
    lbRead(8'h01, 32'h6);
    rd_lat = 2;

    // Asynchronous reset during a stalled write
    $display("[TB] reset mid-write");
    src_valid = 1'b1; src_data = 32'h1234_5678; mem_wait = 1'b1;
    applyStimulus(32'h600, 32'd4, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("pre-reset wren", mem_wren, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset ctl outputs", {mem_wren, mem_rden, src_ready, snk_valid, xfr_done, lb_wr_valid, lb_rd_valid}, 0);
    checkOutput("mid reset addr/wdata", {mem_addr, mem_wdata}, 0);
    src_valid = 1'b0; mem_wait = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    lbRead(8'h01, 32'h0);
    expRead(27'h700, 32'hC0DE_0700);
    expRead(27'h701, 32'hC0DE_0701);
    applyStimulus(32'h700, 32'd2, 1'b0);
    waitDone("post-reset done");
    lbRead(8'h01, 32'h2);

    repeat (4) @(posedge clk);
    checkOutput("req queue drained", exp_req_q.size(), 0);
    checkOutput("snk queue drained", exp_snk_q.size(), 0);
    checkOutput("lb queue drained", exp_lb_q.size(), 0);
    checkOutput("done pulse count", done_seen, exp_done);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
